// File: rtl/comparator.sv
// comparator: signed two's-complement compare of a/b, returns relation flags plus max/min.
// Latency: one cycle from a sampled in_valid pair to out_valid; one pair accepted every cycle.
// Backpressure: none; downstream must consume every out_valid pulse.
module comparator #(
  parameter int WIDTH = 16,
  parameter int FRAC  = 8   // Q-format documentation only; compare is on raw bits
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  output logic             a_greater,
  output logic             a_equal,
  output logic             a_less,
  output logic [WIDTH-1:0] max_val,
  output logic [WIDTH-1:0] min_val
);

  // A fractional field wider than the word is a configuration error.
  generate
    if (FRAC < 0 || FRAC > WIDTH) begin : g_frac_range
      $error("comparator: FRAC must lie in 0..WIDTH");
    end
  endgenerate

  logic             a_gt_b;
  logic             a_eq_b;
  logic             a_ge_b;

  logic             out_valid_d, out_valid_q;
  logic             a_greater_d, a_greater_q;
  logic             a_equal_d,   a_equal_q;
  logic             a_less_d,    a_less_q;
  logic [WIDTH-1:0] max_val_d,   max_val_q;
  logic [WIDTH-1:0] min_val_d,   min_val_q;

  // Magnitude relation via native signed compare: no subtraction, so no overflow at the extremes.
  always_comb begin
    a_gt_b = ($signed(a) > $signed(b));
    a_eq_b = (a == b);
    a_ge_b = a_gt_b | a_eq_b;
  end

  // Next-state: load a new result on in_valid, otherwise hold so idle operands (even X) stay out.
  always_comb begin
    out_valid_d = in_valid;
    a_greater_d = a_greater_q;
    a_equal_d   = a_equal_q;
    a_less_d    = a_less_q;
    max_val_d   = max_val_q;
    min_val_d   = min_val_q;
    if (in_valid) begin
      a_greater_d = a_gt_b;
      a_equal_d   = a_eq_b;
      a_less_d    = ~a_ge_b;
      max_val_d   = a_ge_b ? a : b;
      min_val_d   = a_ge_b ? b : a;
    end
  end

  // Output registers; reset clears everything immediately, independent of clk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      a_greater_q <= 1'b0;
      a_equal_q   <= 1'b0;
      a_less_q    <= 1'b0;
      max_val_q   <= '0;
      min_val_q   <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      a_greater_q <= a_greater_d;
      a_equal_q   <= a_equal_d;
      a_less_q    <= a_less_d;
      max_val_q   <= max_val_d;
      min_val_q   <= min_val_d;
    end
  end

  assign out_valid = out_valid_q;
  assign a_greater = a_greater_q;
  assign a_equal   = a_equal_q;
  assign a_less    = a_less_q;
  assign max_val   = max_val_q;
  assign min_val   = min_val_q;

endmodule

// File: tb/tb_comparator.sv
// tb_comparator: table-driven vectors through a scoreboard queue for the comparator.
// Latency: expects each in_valid pair to surface exactly one cycle later.
// Backpressure: none; the monitor checks every cycle for valid/hold behaviour.
module tb_comparator;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [15:0] a;
  logic [15:0] b;
  logic        out_valid;
  logic        a_greater;
  logic        a_equal;
  logic        a_less;
  logic [15:0] max_val;
  logic [15:0] min_val;

  comparator #(.WIDTH(16), .FRAC(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .a_greater (a_greater),
    .a_equal   (a_equal),
    .a_less    (a_less),
    .max_val   (max_val),
    .min_val   (min_val)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        gt;
    logic        eq;
    logic        lt;
    logic [15:0] mx;
    logic [15:0] mn;
  } vec_t;

  // {gt, eq, lt, max, min} as the DUT should present it
  typedef logic [34:0] exp_t;

  vec_t tbl[14];
  exp_t exp_q[$];
  exp_t hold_exp;
  int   n_vec;
  int   n_err;
  bit   run;

  task automatic chk(input string name, input logic [34:0] act, input logic [34:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  function automatic exp_t pack_exp(input vec_t v);
    return {v.gt, v.eq, v.lt, v.mx, v.mn};
  endfunction

  function automatic exp_t dut_res();
    return {a_greater, a_equal, a_less, max_val, min_val};
  endfunction

  task automatic drive(input vec_t v);
    @(negedge clk);
    in_valid = 1'b1;
    a        = v.a;
    b        = v.b;
    exp_q.push_back(pack_exp(v));
  endtask

  // Monitor: one cycle after each edge, out_valid must match the sampled in_valid;
  // valid results pop the scoreboard, idle cycles must show the held result.
  initial begin
    logic vld_s;
    logic rst_s;
    exp_t e;
    forever begin
      @(posedge clk);
      vld_s = in_valid;
      rst_s = rst;
      #1;
      if (run && !rst_s && !rst) begin
        chk("out_valid", {34'd0, out_valid}, {34'd0, vld_s});
        if (out_valid) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_result", 35'd1, 35'd0);
          end else begin
            e = exp_q.pop_front();
            chk("flags", {32'd0, a_greater, a_equal, a_less}, {32'd0, e[34:32]});
            chk("max_val", {19'd0, max_val}, {19'd0, e[31:16]});
            chk("min_val", {19'd0, min_val}, {19'd0, e[15:0]});
            hold_exp = e;
          end
        end else begin
          chk("hold", dut_res(), hold_exp);
        end
      end
    end
  end

  initial begin
    n_vec    = 0;
    n_err    = 0;
    run      = 1'b0;
    hold_exp = '0;
    rst      = 1'b1;
    in_valid = 1'b0;
    a        = '0;
    b        = '0;

    //              a         b      gt eq lt  max       min
    tbl[0]  = '{16'd2560, 16'd1280, 1, 0, 0, 16'd2560, 16'd1280};  // 10.0 vs 5.0
    tbl[1]  = '{16'hFE00, 16'd768,  0, 0, 1, 16'd768,  16'hFE00};  // -2.0 vs 3.0
    tbl[2]  = '{16'd1792, 16'd1792, 0, 1, 0, 16'd1792, 16'd1792};  // 7.0 == 7.0
    tbl[3]  = '{16'h8000, 16'h7FFF, 0, 0, 1, 16'h7FFF, 16'h8000};  // min vs max
    tbl[4]  = '{16'h7FFF, 16'h8000, 1, 0, 0, 16'h7FFF, 16'h8000};  // max vs min
    tbl[5]  = '{16'h0000, 16'h0000, 0, 1, 0, 16'h0000, 16'h0000};
    tbl[6]  = '{16'hFFFF, 16'h0000, 0, 0, 1, 16'h0000, 16'hFFFF};  // -1 vs 0
    tbl[7]  = '{16'h0000, 16'hFFFF, 1, 0, 0, 16'h0000, 16'hFFFF};  // 0 vs -1
    tbl[8]  = '{16'hFFFF, 16'hFFFE, 1, 0, 0, 16'hFFFF, 16'hFFFE};  // -1 vs -2
    tbl[9]  = '{16'h8000, 16'h8001, 0, 0, 1, 16'h8001, 16'h8000};
    tbl[10] = '{16'h8000, 16'h8000, 0, 1, 0, 16'h8000, 16'h8000};
    tbl[11] = '{16'h0100, 16'h00FF, 1, 0, 0, 16'h0100, 16'h00FF};  // 1.0 vs 0.996
    tbl[12] = '{16'h7FFF, 16'h7FFE, 1, 0, 0, 16'h7FFF, 16'h7FFE};
    tbl[13] = '{16'hC000, 16'h4000, 0, 0, 1, 16'h4000, 16'hC000};  // -64.0 vs 64.0

    // Reset state after a couple of edges held in reset
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", {out_valid, dut_res()}, 36'd0);
    @(negedge clk);
    rst = 1'b0;
    run = 1'b1;

    // Back-to-back table vectors: out_valid must stay high with no bubbles
    for (int i = 0; i < 14; i++) drive(tbl[i]);
    @(negedge clk);
    in_valid = 1'b0;

    // Idle with changing operands: outputs hold the last result
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      a = 16'($urandom);
      b = 16'($urandom);
    end

    // Reset pulse between edges while out_valid=1
    drive(tbl[0]);
    @(posedge clk);
    #2;
    chk("pre_reset_valid", {34'd0, out_valid}, 35'd1);
    rst = 1'b1;
    #1;
    chk("async_reset", {out_valid, dut_res()}, 36'd0);
    exp_q.delete();
    hold_exp = '0;
    #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    a        = 16'h1234;
    b        = 16'h4321;
    repeat (3) @(negedge clk);

    // First valid pair after reset, then idle to confirm the hold again
    drive(tbl[1]);
    drive(tbl[4]);
    @(negedge clk);
    in_valid = 1'b0;
    a        = 16'hFFFF;
    b        = 16'h0001;
    repeat (3) @(negedge clk);

    chk("scoreboard_drain", 35'(exp_q.size()), 35'd0);
    run = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Safety net against a stalled run
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, required completion");
    $fatal(1);
  end

endmodule
